// File: rtl/std_float_pkg.sv
// Shared definitions for the float primitive set: FSM states, recoded class codes, clog2.
package std_float_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fp_state_e;

  localparam logic [2:0] REC_ZERO = 3'b000;
  localparam logic [2:0] REC_INF  = 3'b110;
  localparam logic [2:0] REC_NAN  = 3'b111;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/std_fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module std_fp_lzc #(
  parameter int unsigned W     = 23,
  parameter int unsigned CNT_W = 5
) (
  input  logic [W-1:0]     in_bits,
  output logic [CNT_W-1:0] lz
);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    lz = CNT_W'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (in_bits[i]) lz = CNT_W'(int'(W) - 1 - i);
    end
  end

endmodule

// File: rtl/std_fp_fn_to_recfn_seq.sv
// IEEE-754 to recoded-format converter with go/done handshake and iterative subnormal normalization.
// Define STD_FP_FN_TO_RECFN_FAST_EN to normalize subnormals in one cycle with an LZC and barrel shift.
module std_fp_fn_to_recfn_seq
  import std_float_pkg::*;
#(
  parameter int unsigned expWidth    = 8,
  parameter int unsigned sigWidth    = 24,
  parameter int unsigned inputWidth  = 32,
  parameter int unsigned outputWidth = 33
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [inputWidth-1:0]  in,
  output logic [outputWidth-1:0] out,
  output logic                   done
);

  localparam int unsigned FW  = sigWidth - 1;
  localparam int unsigned REW = expWidth + 1;
  localparam int unsigned CW  = clog2(sigWidth);
  localparam logic [REW-1:0] BIAS_P1 = REW'((2 ** (expWidth - 1)) + 1);

  fp_state_e              state_q, state_d;
  logic                   sign_q, sign_d;
  logic [FW-1:0]          shreg_q, shreg_d;
  logic [CW-1:0]          count_q, count_d;
  logic [outputWidth-1:0] out_q, out_d;
  logic                   done_q, done_d;

  logic                in_sign;
  logic [expWidth-1:0] in_exp;
  logic [FW-1:0]       in_fract;
  logic [REW-1:0]      norm_exp;
  logic                exp_ones;

  assign in_sign  = in[inputWidth-1];
  assign in_exp   = in[inputWidth-2 -: expWidth];
  assign in_fract = in[FW-1:0];
  assign norm_exp = REW'(in_exp) + BIAS_P1;
  assign exp_ones = &in_exp;

`ifdef STD_FP_FN_TO_RECFN_FAST_EN
  logic [CW-1:0] lz;
  logic [FW-1:0] fast_fract;

  std_fp_lzc #(.W(FW), .CNT_W(CW)) u_lzc (
    .in_bits (in_fract),
    .lz      (lz)
  );

  // Shift past the leading one so the hidden bit falls off the top.
  assign fast_fract = in_fract << (lz + CW'(1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      shreg_q <= '0;
      count_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    shreg_d = shreg_q;
    count_d = count_q;
    out_d   = out_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          sign_d = in_sign;
          if (exp_ones) begin
            out_d   = {in_sign, (in_fract == '0) ? REC_INF : REC_NAN,
                       norm_exp[REW-4:0], in_fract};
            state_d = DONE;
            done_d  = 1'b1;
          end else if (in_exp == '0 && in_fract == '0) begin
            out_d   = {in_sign, REC_ZERO, (REW-3)'(0), FW'(0)};
            state_d = DONE;
            done_d  = 1'b1;
          end else if (in_exp != '0) begin
            out_d   = {in_sign, norm_exp, in_fract};
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
`ifdef STD_FP_FN_TO_RECFN_FAST_EN
            out_d   = {in_sign, BIAS_P1 - REW'(lz), fast_fract};
            state_d = DONE;
            done_d  = 1'b1;
`else
            shreg_d = in_fract;
            count_d = '0;
            state_d = SHIFT;
`endif
          end
        end
      end
      SHIFT: begin
        // Leading one reached: it becomes the implicit bit and is dropped.
        if (shreg_q[FW-1]) begin
          out_d   = {sign_q, BIAS_P1 - REW'(count_q), shreg_q[FW-2:0], 1'b0};
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          shreg_d = {shreg_q[FW-2:0], 1'b0};
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out  = out_q;
  assign done = done_q;

endmodule
